cpu_seq_ctrl: RTL

- Multi-cycle sequencer for the single-issue RV32 core.
- Drives one shared datapath (PC, IR, ALU, regfile, data memory) through FETCH/DECODE/EXEC/MEM/WB.
- Consumes the decoder's control flags and the memory ready handshakes.
- Produces every enable/select for the datapath; one instruction is in flight at a time.

---
 rtl/cpu_seq_ctrl_pkg.sv | 36 +++
 rtl/cpu_seq_ctrl_if.sv | 43 ++++
 rtl/cpu_seq_ctrl_timeout.sv | 38 +++
 rtl/cpu_seq_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl_pkg
// Shared constants for the multi-cycle RV32 sequencer: state codes, PC and
// write-back select encodings, and the latched decoder-flag bundle.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_seq_ctrl_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] sel_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_ERR    = 3'd5;

    localparam sel_t PC_SEL_PC4 = 2'd0;
    localparam sel_t PC_SEL_BR  = 2'd1;
    localparam sel_t PC_SEL_JMP = 2'd2;

    localparam sel_t WB_SEL_ALU = 2'd0;
    localparam sel_t WB_SEL_MEM = 2'd1;
    localparam sel_t WB_SEL_PC4 = 2'd2;

    typedef struct packed {
        logic branch;
        logic jump;
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
    } dec_flags_t;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl_if
// Bundle between the sequencer and the datapath/memories: memory request and
// ready handshakes, decoder flags, branch result and all datapath enables.
// Modports:
//   master - the sequencer (drives requests/enables, reads readies/flags)
//   slave  - datapath and memory side (the reverse)
// -----------------------------------------------------------------------------
interface cpu_seq_ctrl_if;
    import cpu_seq_ctrl_pkg::*;

    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;
    logic branch;
    logic jump;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic memtoreg;
    logic illegal;
    logic br_taken;
    logic ir_we;
    logic pc_we;
    sel_t pc_sel;
    logic rf_we;
    sel_t wb_sel;

    modport master (
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
        input  imem_ready, dmem_ready, branch, jump, memread, memwrite,
               regwrite, memtoreg, illegal, br_taken
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
        output imem_ready, dmem_ready, branch, jump, memread, memwrite,
               regwrite, memtoreg, illegal, br_taken
    );

endinterface

// File: rtl/cpu_seq_ctrl_timeout.sv
// -----------------------------------------------------------------------------
// seq_timeout_cnt
// Memory wait counter with an expire flag. Counts cycles while en is high,
// returns to zero on clr. expired is asserted once the count equals
// MEM_TIMEOUT; MEM_TIMEOUT = 0 means the flag never asserts.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clr         - restart the count
//   en          - a request is waiting for ready this cycle
//   expired     - count has reached MEM_TIMEOUT
// -----------------------------------------------------------------------------
module seq_timeout_cnt #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt;

    assign expired = (MEM_TIMEOUT != 0) && (cnt == LIMIT);

    // Stops at LIMIT so the flag cannot wrap away while the FSM is leaving.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl
// Multi-cycle sequencer for the single-issue RV32 core. Walks one instruction
// at a time through FETCH/DECODE/EXEC/MEM/WB and produces every enable and
// select for the shared datapath. A memory request that waits MEM_TIMEOUT
// cycles, an illegal opcode or a bad state code lands in ERR until reset.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   bus          - cpu_seq_ctrl_if.master: requests, readies, decoder flags,
//                  br_taken, ir_we, pc_we, pc_sel, rf_we, wb_sel
//   err          - sticky error flag
//   state        - current state code (debug)
//   cycle_cnt,
//   instret_cnt  - performance counters, present only when
//                  CPU_SEQ_PERF_CNT_EN is defined (CNT_W bits, wrapping)
// -----------------------------------------------------------------------------
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
`ifdef CPU_SEQ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_seq_ctrl_if.master       bus,
    output logic                 err,
    output logic [2:0]           state
`ifdef CPU_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
`endif
);

    state_t     state_r;
    state_t     state_nxt;
    dec_flags_t flags_r;
    // Low for the cycle(s) where reset was sampled; gates every output so
    // nothing is requested or enabled while reset is held.
    logic       run;
    logic       expired;
    logic       waiting;

    logic imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, rf_we_c, err_c;
    sel_t pc_sel_c, wb_sel_c;

    seq_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!waiting),
        .en      (waiting),
        .expired (expired)
    );

    // A transfer completing (or no request at all) restarts the count, so it
    // is always zero on entry to FETCH or MEM.
    assign waiting = (imem_req_c && !bus.imem_ready) || (dmem_req_c && !bus.dmem_ready);

    always_comb begin
        state_nxt  = state_r;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = PC_SEL_PC4;
        rf_we_c    = 1'b0;
        wb_sel_c   = WB_SEL_ALU;
        err_c      = 1'b0;
        if (run) begin
            case (state_r)
                ST_FETCH: begin
                    imem_req_c = 1'b1;
                    if (bus.imem_ready) begin
                        ir_we_c   = 1'b1;
                        state_nxt = ST_DECODE;
                    end else if (expired) begin
                        state_nxt = ST_ERR;
                    end
                end
                ST_DECODE: begin
                    state_nxt = bus.illegal ? ST_ERR : ST_EXEC;
                end
                ST_EXEC: begin
                    if (flags_r.branch) begin
                        pc_we_c   = 1'b1;
                        pc_sel_c  = bus.br_taken ? PC_SEL_BR : PC_SEL_PC4;
                        state_nxt = ST_FETCH;
                    end else if (flags_r.memread || flags_r.memwrite) begin
                        state_nxt = ST_MEM;
                    end else if (flags_r.jump || flags_r.regwrite) begin
                        state_nxt = ST_WB;
                    end else begin
                        pc_we_c   = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
                ST_MEM: begin
                    dmem_req_c = 1'b1;
                    // memread together with memwrite is handled as a load.
                    dmem_we_c  = flags_r.memwrite && !flags_r.memread;
                    if (bus.dmem_ready) begin
                        if (flags_r.memread) begin
                            state_nxt = ST_WB;
                        end else begin
                            pc_we_c   = 1'b1;
                            state_nxt = ST_FETCH;
                        end
                    end else if (expired) begin
                        state_nxt = ST_ERR;
                    end
                end
                ST_WB: begin
                    rf_we_c   = flags_r.regwrite || flags_r.memtoreg;
                    wb_sel_c  = flags_r.jump ? WB_SEL_PC4 :
                                flags_r.memtoreg ? WB_SEL_MEM : WB_SEL_ALU;
                    pc_we_c   = 1'b1;
                    pc_sel_c  = flags_r.jump ? PC_SEL_JMP : PC_SEL_PC4;
                    state_nxt = ST_FETCH;
                end
                ST_ERR: begin
                    err_c = 1'b1;
                end
                default: begin
                    state_nxt = ST_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            run     <= 1'b0;
        end else begin
            state_r <= state_nxt;
            run     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_r == ST_DECODE) begin
            flags_r <= '{branch:   bus.branch,
                         jump:     bus.jump,
                         memread:  bus.memread,
                         memwrite: bus.memwrite,
                         regwrite: bus.regwrite,
                         memtoreg: bus.memtoreg};
        end
    end

`ifdef CPU_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_r != ST_ERR) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (pc_we_c) begin
                instret_cnt <= instret_cnt + 1'b1;
            end
        end
    end
`endif

    assign bus.imem_req = imem_req_c;
    assign bus.dmem_req = dmem_req_c;
    assign bus.dmem_we  = dmem_we_c;
    assign bus.ir_we    = ir_we_c;
    assign bus.pc_we    = pc_we_c;
    assign bus.pc_sel   = pc_sel_c;
    assign bus.rf_we    = rf_we_c;
    assign bus.wb_sel   = wb_sel_c;
    assign err          = err_c;
    assign state        = state_r;

endmodule
